world_editor: RTL and testbench

- Parametrised successor to the voxel world-change FSM.
- Runs one edit command per start pulse against the block-world RAM: PLACE, DELETE or CLEAR_PLANE.
- Sits between the ray-cast "looked-at" logic and the dual-port world RAM.
- Supports configurable RAM read latency and reports a status code and edit count. Camera motion is handled elsewhere, not in this block.

---
 rtl/world_editor.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_world_editor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/world_editor.sv
// world_editor: runs one PLACE / DELETE / CLEAR_PLANE edit per start pulse
// against the dual-port block-world RAM.
// Build option WORLD_EDITOR_DEDUP_EN: PLACE scans the whole world, refuses to
// duplicate an existing cube (status EXISTS) and commits into the first free
// slot in a one-cycle COMMIT state.
// Handshake: start is a request accepted only in IDLE (there is no ready);
// busy is high from the cycle after accept through the done cycle; done is a
// one-cycle pulse; world_we is a one-cycle strobe with world_write_addr and
// world_write valid in that same cycle.
module world_editor #(
  parameter int COORD_W      = 16,
  parameter int WORLD_BITS   = 7,
  parameter int WORLD_SIZE   = 128,
  parameter int NORMAL_WIDTH = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start,
  input  logic [1:0]                cmd,
  input  logic [1:0]                plane_axis,
  input  logic [COORD_W-1:0]        plane_val,
  input  logic [WORLD_BITS-1:0]     looked_at_cube,
  input  logic [3*NORMAL_WIDTH-1:0] looked_at_normal,
  input  logic [3*COORD_W:0]        world_read,
  output logic [WORLD_BITS-1:0]     world_read_addr,
  output logic [WORLD_BITS-1:0]     world_write_addr,
  output logic [3*COORD_W:0]        world_write,
  output logic                      world_we,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                status,
  output logic [WORLD_BITS:0]       edit_count,
  output logic [2:0]                dbg_state
);
  localparam int PH_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [PH_W-1:0]       LAST_PH   = PH_W'(READ_LATENCY);
  localparam logic [WORLD_BITS-1:0] LAST_ADDR = WORLD_BITS'(WORLD_SIZE - 1);
  localparam logic [WORLD_BITS:0]   CNT_MAX   = (WORLD_BITS + 1)'(WORLD_SIZE);

  localparam logic [1:0] CMD_PLACE  = 2'd1;
  localparam logic [1:0] CMD_DELETE = 2'd2;
  localparam logic [1:0] CMD_CLEAR  = 2'd3;
  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_FULL      = 2'd1;
  localparam logic [1:0] ST_NOT_FOUND = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SCAN, S_COMMIT, S_DONE} state_t;

  state_t                    r_state, w_next;
  logic [1:0]                r_cmd, r_axis, r_res, r_status;
  logic [COORD_W-1:0]        r_plane_val, r_fx, r_fy, r_fz;
  logic [WORLD_BITS-1:0]     r_cube, r_addr;
  logic [3*NORMAL_WIDTH-1:0] r_normal;
  logic [PH_W-1:0]           r_phase;
  logic [WORLD_BITS:0]       r_cnt, r_edit_count;
`ifdef WORLD_EDITOR_DEDUP_EN
  logic                      r_free_found, r_exists;
  logic [WORLD_BITS-1:0]     r_free_addr;
  logic                      w_match_target;
`endif

  logic                      w_rd_valid, w_eval, w_last, w_match_fetch, w_match_plane;
  logic [COORD_W-1:0]        w_rd_x, w_rd_y, w_rd_z, w_plane_coord;
  logic [COORD_W-1:0]        w_nx, w_ny, w_nz, w_tx, w_ty, w_tz;

  assign w_rd_valid = world_read[3*COORD_W];
  assign w_rd_x     = world_read[3*COORD_W-1:2*COORD_W];
  assign w_rd_y     = world_read[2*COORD_W-1:COORD_W];
  assign w_rd_z     = world_read[COORD_W-1:0];
  assign w_eval     = (r_phase == LAST_PH);
  assign w_last     = (r_addr == LAST_ADDR);

  // Face normal components are sign-extended; the sum wraps modulo 2^COORD_W.
  assign w_nx = {{(COORD_W-NORMAL_WIDTH){r_normal[NORMAL_WIDTH-1]}}, r_normal[NORMAL_WIDTH-1:0]};
  assign w_ny = {{(COORD_W-NORMAL_WIDTH){r_normal[2*NORMAL_WIDTH-1]}}, r_normal[2*NORMAL_WIDTH-1:NORMAL_WIDTH]};
  assign w_nz = {{(COORD_W-NORMAL_WIDTH){r_normal[3*NORMAL_WIDTH-1]}}, r_normal[3*NORMAL_WIDTH-1:2*NORMAL_WIDTH]};
  assign w_tx = r_fx + w_nx;
  assign w_ty = r_fy + w_ny;
  assign w_tz = r_fz + w_nz;

  assign w_match_fetch = w_rd_valid && ({w_rd_x, w_rd_y, w_rd_z} == {r_fx, r_fy, r_fz});
  assign w_match_plane = w_rd_valid && (w_plane_coord == r_plane_val);
`ifdef WORLD_EDITOR_DEDUP_EN
  assign w_match_target = w_rd_valid && ({w_rd_x, w_rd_y, w_rd_z} == {w_tx, w_ty, w_tz});
`endif

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign status     = done ? r_res : r_status;
  assign edit_count = done ? r_cnt : r_edit_count;
  assign dbg_state  = r_state;

  // Select the coordinate that CLEAR_PLANE compares against plane_val.
  always_comb begin
    w_plane_coord = w_rd_x;
    case (r_axis)
      2'd1:    w_plane_coord = w_rd_y;
      2'd2:    w_plane_coord = w_rd_z;
      default: w_plane_coord = w_rd_x;
    endcase
  end

  // Next-state logic plus RAM address and write-strobe generation.
  always_comb begin
    w_next           = r_state;
    world_read_addr  = '0;
    world_write_addr = '0;
    world_write      = '0;
    world_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (cmd)
            CMD_PLACE, CMD_DELETE: w_next = S_FETCH;
            CMD_CLEAR:             w_next = (plane_axis == 2'd3) ? S_DONE : S_SCAN;
            default:               w_next = S_DONE;
          endcase
        end
      end
      S_FETCH: begin
        world_read_addr = r_cube;
        if (w_eval) w_next = w_rd_valid ? S_SCAN : S_DONE;
      end
      S_SCAN: begin
        world_read_addr = r_addr;
        if (w_eval) begin
          case (r_cmd)
            CMD_PLACE: begin
`ifndef WORLD_EDITOR_DEDUP_EN
              if (!w_rd_valid) begin
                world_we         = 1'b1;
                world_write_addr = r_addr;
                world_write      = {1'b1, w_tx, w_ty, w_tz};
                w_next           = S_DONE;
              end
`endif
            end
            CMD_DELETE: begin
              if (w_match_fetch) begin
                world_we         = 1'b1;
                world_write_addr = r_addr;
                world_write      = {1'b0, w_rd_x, w_rd_y, w_rd_z};
              end
            end
            CMD_CLEAR: begin
              if (w_match_plane) begin
                world_we         = 1'b1;
                world_write_addr = r_addr;
                world_write      = {1'b0, w_rd_x, w_rd_y, w_rd_z};
              end
            end
            default: ;
          endcase
          if (w_last && (w_next == S_SCAN)) begin
`ifdef WORLD_EDITOR_DEDUP_EN
            w_next = (r_cmd == CMD_PLACE) ? S_COMMIT : S_DONE;
`else
            w_next = S_DONE;
`endif
          end
        end
      end
`ifdef WORLD_EDITOR_DEDUP_EN
      S_COMMIT: begin
        if (!r_exists && r_free_found) begin
          world_we         = 1'b1;
          world_write_addr = r_free_addr;
          world_write      = {1'b1, w_tx, w_ty, w_tz};
        end
        w_next = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any command immediately.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Command latch, scan counters, write count and result bookkeeping.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cmd        <= '0;
      r_axis       <= '0;
      r_plane_val  <= '0;
      r_cube       <= '0;
      r_normal     <= '0;
      r_fx         <= '0;
      r_fy         <= '0;
      r_fz         <= '0;
      r_addr       <= '0;
      r_phase      <= '0;
      r_cnt        <= '0;
      r_res        <= ST_OK;
      r_status     <= ST_OK;
      r_edit_count <= '0;
`ifdef WORLD_EDITOR_DEDUP_EN
      r_free_found <= 1'b0;
      r_exists     <= 1'b0;
      r_free_addr  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cmd       <= cmd;
            r_axis      <= plane_axis;
            r_plane_val <= plane_val;
            r_cube      <= looked_at_cube;
            r_normal    <= looked_at_normal;
            r_addr      <= '0;
            r_phase     <= '0;
            r_cnt       <= '0;
            r_res       <= ST_OK;
`ifdef WORLD_EDITOR_DEDUP_EN
            r_free_found <= 1'b0;
            r_exists     <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (w_eval) begin
            r_phase <= '0;
            r_fx    <= w_rd_x;
            r_fy    <= w_rd_y;
            r_fz    <= w_rd_z;
            if (!w_rd_valid) r_res <= ST_NOT_FOUND;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_SCAN: begin
          if (w_eval) begin
            r_phase <= '0;
            r_addr  <= r_addr + 1'b1;
            if (world_we && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
`ifdef WORLD_EDITOR_DEDUP_EN
            if (r_cmd == CMD_PLACE) begin
              if (!w_rd_valid && !r_free_found) begin
                r_free_found <= 1'b1;
                r_free_addr  <= r_addr;
              end
              if (w_match_target) r_exists <= 1'b1;
            end
`endif
            if (w_last && !world_we) begin
`ifndef WORLD_EDITOR_DEDUP_EN
              if (r_cmd == CMD_PLACE) r_res <= ST_FULL;
`endif
              if ((r_cmd == CMD_DELETE) && (r_cnt == '0)) r_res <= ST_NOT_FOUND;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
`ifdef WORLD_EDITOR_DEDUP_EN
        S_COMMIT: begin
          if (r_exists) begin
            r_res <= 2'd3;
          end else if (r_free_found) begin
            r_res <= ST_OK;
            r_cnt <= (WORLD_BITS + 1)'(1);
          end else begin
            r_res <= ST_FULL;
          end
        end
`endif
        S_DONE: begin
          r_status     <= r_res;
          r_edit_count <= r_cnt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_world_editor.sv
// tb_world_editor: directed and randomized edit commands against a behavioural
// world RAM; expected writes, status, count and latency come from a
// whole-world reference model evaluated on the RAM contents at command start.
module tb_world_editor;
  localparam int COORD_W      = 16;
  localparam int WORLD_BITS   = 7;
  localparam int WORLD_SIZE   = 128;
  localparam int NORMAL_WIDTH = 2;
  localparam int READ_LATENCY = 2;
  localparam int DATA_W       = 3*COORD_W+1;
  localparam int EXP_W        = WORLD_BITS+DATA_W;
  localparam int BUDGET       = 2000;

  logic                      clk_in, rst_in, start;
  logic [1:0]                cmd, plane_axis;
  logic [COORD_W-1:0]        plane_val;
  logic [WORLD_BITS-1:0]     looked_at_cube;
  logic [3*NORMAL_WIDTH-1:0] looked_at_normal;
  logic [DATA_W-1:0]         world_read;
  logic [WORLD_BITS-1:0]     world_read_addr, world_write_addr;
  logic [DATA_W-1:0]         world_write;
  logic                      world_we, busy, done;
  logic [1:0]                status;
  logic [WORLD_BITS:0]       edit_count;
  logic [2:0]                dbg_state;

  int compared   = 0;
  int mismatched = 0;
  int n_writes   = 0;
  logic [EXP_W-1:0]      exp_q[$];
  logic [DATA_W-1:0]     mem[WORLD_SIZE];
  logic [DATA_W-1:0]     init_mem[WORLD_SIZE];
  logic [DATA_W-1:0]     rd_pipe[READ_LATENCY];
  logic                  load_all;
  logic [WORLD_BITS-1:0] last_waddr;
  logic [DATA_W-1:0]     last_wdata;

  world_editor #(
    .COORD_W(COORD_W), .WORLD_BITS(WORLD_BITS), .WORLD_SIZE(WORLD_SIZE),
    .NORMAL_WIDTH(NORMAL_WIDTH), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .cmd(cmd),
    .plane_axis(plane_axis), .plane_val(plane_val),
    .looked_at_cube(looked_at_cube), .looked_at_normal(looked_at_normal),
    .world_read(world_read), .world_read_addr(world_read_addr),
    .world_write_addr(world_write_addr), .world_write(world_write),
    .world_we(world_we), .busy(busy), .done(done), .status(status),
    .edit_count(edit_count), .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // World RAM: bulk load from the bench, writes from the DUT, pipelined read.
  always @(posedge clk_in) begin
    if (load_all) begin
      for (int i = 0; i < WORLD_SIZE; i++) mem[i] <= init_mem[i];
    end else if (world_we) begin
      mem[world_write_addr] <= world_write;
    end
    rd_pipe[0] <= mem[world_read_addr];
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign world_read = rd_pipe[READ_LATENCY-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk_in) begin
    if (world_we) begin
      n_writes++;
      last_waddr = world_write_addr;
      last_wdata = world_write;
      check("we_while_busy", 64'(busy), 64'd1);
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write", 64'({world_write_addr, world_write}), 64'(exp_q.pop_front()));
    end
  end

  function automatic logic [DATA_W-1:0] mk(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {v, x, y, z};
  endfunction

  function automatic logic [15:0] add_n(input logic [15:0] a, input logic [1:0] n);
    int s;
    s = int'(a) + int'($signed(n));
    return s[15:0];
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0:       return 16'd0;
      1:       return 16'd1;
      2:       return 16'd2;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic load_world();
    @(negedge clk_in);
    load_all = 1'b1;
    @(negedge clk_in);
    load_all = 1'b0;
  endtask

  // Reference model: whole-world evaluation of one command on the current RAM.
  task automatic model(input logic [1:0] c, input logic [1:0] ax, input logic [15:0] pv,
                       input logic [6:0] cube, input logic [5:0] nrm,
                       output logic [1:0] st, output logic [7:0] cnt, output int lat);
    logic [DATA_W-1:0] src, e;
    logic [47:0] tgt;
    int n, ff, sel_lo;
    bit present;
    st = 2'd0; cnt = 8'd0; lat = -1; n = 0; ff = -1; present = 0;
    case (c)
      2'd1: begin
        src = mem[cube];
        if (!src[48]) st = 2'd2;
        else begin
          tgt = {add_n(src[47:32], nrm[1:0]), add_n(src[31:16], nrm[3:2]), add_n(src[15:0], nrm[5:4])};
          for (int i = 0; i < WORLD_SIZE; i++) begin
            e = mem[i];
            if (!e[48] && ff < 0) ff = i;
            if (e[48] && e[47:0] == tgt) present = 1;
          end
`ifdef WORLD_EDITOR_DEDUP_EN
          if (present) st = 2'd3;
          else if (ff >= 0) begin exp_q.push_back({7'(ff), 1'b1, tgt}); cnt = 8'd1; end
          else st = 2'd1;
`else
          if (ff >= 0) begin exp_q.push_back({7'(ff), 1'b1, tgt}); cnt = 8'd1; end
          else st = 2'd1;
`endif
        end
      end
      2'd2: begin
        src = mem[cube];
        if (!src[48]) st = 2'd2;
        else begin
          lat = (READ_LATENCY+1)*(WORLD_SIZE+1)+1;
          for (int i = 0; i < WORLD_SIZE; i++) begin
            e = mem[i];
            if (e[48] && e[47:0] == src[47:0]) begin exp_q.push_back({7'(i), 1'b0, e[47:0]}); n++; end
          end
          cnt = 8'((n > WORLD_SIZE) ? WORLD_SIZE : n);
          st = (n == 0) ? 2'd2 : 2'd0;
        end
      end
      2'd3: begin
        if (ax == 2'd3) lat = 1;
        else begin
          lat = (READ_LATENCY+1)*WORLD_SIZE+1;
          sel_lo = (2 - int'(ax)) * 16;
          for (int i = 0; i < WORLD_SIZE; i++) begin
            e = mem[i];
            if (e[48] && ((e >> sel_lo) & 49'hFFFF) == 49'(pv)) begin
              exp_q.push_back({7'(i), 1'b0, e[47:0]}); n++;
            end
          end
          cnt = 8'((n > WORLD_SIZE) ? WORLD_SIZE : n);
        end
      end
      default: lat = 1;
    endcase
  endtask

  // Driver: issue one command, scramble inputs while busy, check completion.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [1:0] ax,
                         input logic [15:0] pv, input logic [6:0] cube, input logic [5:0] nrm,
                         output int cyc);
    logic [1:0] est; logic [7:0] ecnt; int elat; bit seen;
    model(c, ax, pv, cube, nrm, est, ecnt, elat);
    @(negedge clk_in);
    start = 1'b1; cmd = c; plane_axis = ax; plane_val = pv;
    looked_at_cube = cube; looked_at_normal = nrm;
    cyc = 0; seen = 0;
    while (!seen && cyc < BUDGET) begin
      @(posedge clk_in);
      cyc++;
      @(negedge clk_in);
      if (cyc == 1) check({tag, "_busy_rise"}, 64'(busy), 64'd1);
      if (done) seen = 1;
      else begin
        start = 1'($urandom_range(0, 1)); cmd = 2'($urandom_range(0, 3));
        plane_axis = 2'($urandom_range(0, 3)); plane_val = 16'($urandom);
        looked_at_cube = 7'($urandom); looked_at_normal = 6'($urandom);
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      if (elat >= 0) check({tag, "_latency"}, 64'(cyc), 64'(elat));
      check({tag, "_status"}, 64'(status), 64'(est));
      check({tag, "_edit_count"}, 64'(edit_count), 64'(ecnt));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
      @(negedge clk_in);
      check({tag, "_busy_fall"}, 64'({busy, done}), 64'd0);
      check({tag, "_status_hold"}, 64'({status, edit_count}), 64'({est, ecnt}));
    end
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Directed steps followed by randomized commands.
  initial begin
    int cyc, wb;
    rst_in = 1'b1; start = 1'b0; cmd = '0; plane_axis = '0; plane_val = '0;
    looked_at_cube = '0; looked_at_normal = '0; load_all = 1'b0;
    last_waddr = '0; last_wdata = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_outputs", 64'({busy, done, status, edit_count, world_we}), 64'd0);
    check("reset_addrs", 64'({world_read_addr, world_write_addr}), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("idle_after_reset", 64'({busy, done}), 64'd0);

    // PLACE above cube 5 into the first free slot (6).
    for (int i = 0; i < WORLD_SIZE; i++) init_mem[i] = mk(1'b0, 16'(i), 16'd0, 16'd0);
    for (int i = 0; i < 5; i++) init_mem[i] = mk(1'b1, 16'(100 + i), 16'd9, 16'd9);
    init_mem[5] = mk(1'b1, 16'd3, 16'd0, 16'd2);
    load_world();
    run_cmd("place", 2'd1, 2'd0, 16'd0, 7'd5, 6'b00_01_00, cyc);
    check("place_addr", 64'(last_waddr), 64'd6);
    check("place_data", 64'(last_wdata), 64'(mk(1'b1, 16'd3, 16'd1, 16'd2)));

    // Same PLACE again: target {3,1,2} now present.
    wb = n_writes;
    run_cmd("place_dup", 2'd1, 2'd0, 16'd0, 7'd5, 6'b00_01_00, cyc);
`ifdef WORLD_EDITOR_DEDUP_EN
    check("place_dup_status", 64'(status), 64'd3);
    check("place_dup_nowrite", 64'(n_writes - wb), 64'd0);
`else
    check("place_dup_status", 64'(status), 64'd0);
    check("place_dup_write", 64'(n_writes - wb), 64'd1);
`endif

    // DELETE with a duplicate at 40.
    for (int i = 0; i < WORLD_SIZE; i++) init_mem[i] = mk(1'($urandom), 16'(200 + i), 16'd1, 16'd1);
    init_mem[10] = mk(1'b1, 16'hFFFF, 16'd4, 16'd7);
    init_mem[40] = mk(1'b1, 16'hFFFF, 16'd4, 16'd7);
    load_world();
    run_cmd("delete", 2'd2, 2'd0, 16'd0, 7'd10, 6'd0, cyc);
    check("delete_cycle_388", 64'(cyc), 64'd388);
    check("delete_edit_count", 64'(edit_count), 64'd2);
    check("delete_valid_bits", 64'({mem[10][48], mem[40][48]}), 64'd0);

    // CLEAR_PLANE y == 0 over y = 0,0,2,0.
    for (int i = 0; i < WORLD_SIZE; i++) init_mem[i] = mk(1'b0, 16'd0, 16'd0, 16'd0);
    init_mem[0] = mk(1'b1, 16'd5, 16'd0, 16'd1);
    init_mem[1] = mk(1'b1, 16'd6, 16'd0, 16'd2);
    init_mem[2] = mk(1'b1, 16'd7, 16'd2, 16'd3);
    init_mem[3] = mk(1'b1, 16'd8, 16'd0, 16'd4);
    load_world();
    wb = n_writes;
    run_cmd("clear", 2'd3, 2'd1, 16'd0, 7'd0, 6'd0, cyc);
    check("clear_writes", 64'(n_writes - wb), 64'd3);
    check("clear_untouched", 64'(mem[2]), 64'(mk(1'b1, 16'd7, 16'd2, 16'd3)));

    // Full world.
    for (int i = 0; i < WORLD_SIZE; i++) init_mem[i] = mk(1'b1, 16'(i), 16'd50, 16'd50);
    load_world();
    wb = n_writes;
    run_cmd("full", 2'd1, 2'd0, 16'd0, 7'd3, 6'b01_00_00, cyc);
    check("full_status", 64'({status, edit_count}), 64'({2'd1, 8'd0}));
    check("full_nowrite", 64'(n_writes - wb), 64'd0);

    // NOP, CLEAR with axis 3, DELETE of an empty entry.
    run_cmd("nop", 2'd0, 2'd0, 16'd0, 7'd0, 6'd0, cyc);
    run_cmd("clear_axis3", 2'd3, 2'd3, 16'd0, 7'd0, 6'd0, cyc);
    init_mem[9] = mk(1'b0, 16'd9, 16'd50, 16'd50);
    load_world();
    run_cmd("delete_nf", 2'd2, 2'd0, 16'd0, 7'd9, 6'd0, cyc);
    check("delete_nf_status", 64'(status), 64'd2);

    // Reset in cycle 20 of a DELETE scan.
    for (int i = 0; i < WORLD_SIZE; i++) init_mem[i] = mk(1'b0, 16'd0, 16'd0, 16'd0);
    init_mem[10] = mk(1'b1, 16'hFFFF, 16'd4, 16'd7);
    init_mem[40] = mk(1'b1, 16'hFFFF, 16'd4, 16'd7);
    load_world();
    wb = n_writes;
    @(negedge clk_in);
    start = 1'b1; cmd = 2'd2; looked_at_cube = 7'd10;
    @(posedge clk_in);
    @(negedge clk_in);
    start = 1'b0;
    repeat (18) @(negedge clk_in);
    check("rst_busy_before", 64'(busy), 64'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_mid_outputs", 64'({busy, done, status, edit_count, world_we}), 64'd0);
    repeat (60) @(negedge clk_in);
    check("rst_mid_nowrite", 64'(n_writes - wb), 64'd0);
    check("rst_mid_idle", 64'({busy, done}), 64'd0);

    // Randomized commands over small coordinate sets to force matches.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < WORLD_SIZE; i++)
        init_mem[i] = mk((it % 5 == 0) ? 1'b1 : 1'($urandom), pick(), pick(), pick());
      load_world();
      run_cmd("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(),
              7'($urandom), 6'($urandom), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
